// File: rtl/memory_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// memory_arbiter_pkg
// Shared types for the cache-to-memory arbiter:
//   arb_state_t : arbiter FSM states (IDLE, BUSY, RESP)
//   port_id_t   : requester identity (PORT_IMEM, PORT_DMEM)
//   line_offset_bits() : byte-offset width of one cache line
// ---------------------------------------------------------------------------
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_IMEM = 1'b0,
    PORT_DMEM = 1'b1
  } port_id_t;

  // Number of address bits that select a byte inside one line.
  function automatic int line_offset_bits(input int line_bits);
    return $clog2(line_bits / 8);
  endfunction

endpackage

// File: rtl/memory_arbiter_main_memory_array.sv
// ---------------------------------------------------------------------------
// main_memory_array
// Synchronous single-port line store shared by both cache ports.
// Ports:
//   clk    in   clock
//   en     in   access strobe for this cycle
//   we     in   1 = write wdata to line index, 0 = read line into rdata
//   index  in   line index
//   wdata  in   line to write
//   rdata  out  line read, valid the cycle after a read strobe, held otherwise
// Contents are never reset.
// ---------------------------------------------------------------------------
module main_memory_array #(
  parameter int    WIDTH     = 128,
  parameter int    DEPTH     = 4096,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] index,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rdata_r;

  // Single-port access: a write does not disturb the read register.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_r[index] <= wdata;
      end else begin
        rdata_r <= mem_r[index];
      end
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter
// Arbitrates icache and dcache line requests onto one backing store with a
// fixed access latency and returns each completion as a one-cycle ready pulse.
// Ports:
//   clk, reset (async, active-low)
//   in_{imem,dmem}_read_en / write_en : level-held requests (both high = write)
//   in_{imem,dmem}_addr               : byte address (offset ignored, wraps)
//   in_{imem,dmem}_write_data         : line to write
//   out_{imem,dmem}_read_data         : last line read for that port
//   out_{imem,dmem}_ready             : completion pulse
// ---------------------------------------------------------------------------
module memory_arbiter #(
  parameter int    CACHE_LINE_SIZE = 128,
  parameter int    MEM_DEPTH       = 4096,
  parameter int    MEM_LATENCY     = 5,
  parameter string MEM_INIT_FILE   = ""
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_imem_read_en,
  input  logic                       in_imem_write_en,
  input  logic [31:0]                in_imem_addr,
  input  logic [CACHE_LINE_SIZE-1:0] in_imem_write_data,
  output logic [CACHE_LINE_SIZE-1:0] out_imem_read_data,
  output logic                       out_imem_ready,
  input  logic                       in_dmem_read_en,
  input  logic                       in_dmem_write_en,
  input  logic [31:0]                in_dmem_addr,
  input  logic [CACHE_LINE_SIZE-1:0] in_dmem_write_data,
  output logic [CACHE_LINE_SIZE-1:0] out_dmem_read_data,
  output logic                       out_dmem_ready
);

  import memory_arbiter_pkg::*;

  localparam int OFF_W = line_offset_bits(CACHE_LINE_SIZE);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("memory_arbiter: MEM_LATENCY must be at least 1");
  end
  if ((1 << IDX_W) != MEM_DEPTH) begin : g_bad_depth
    $error("memory_arbiter: MEM_DEPTH must be a power of two");
  end

  arb_state_t                 state_r;
  logic [CNT_W-1:0]           cnt_r;
  port_id_t                   last_grant_r;
  port_id_t                   req_port_r;
  logic                       req_write_r;
  logic [IDX_W-1:0]           req_index_r;
  logic [CACHE_LINE_SIZE-1:0] req_wdata_r;
  logic                       imem_ready_r;
  logic                       dmem_ready_r;
  logic [CACHE_LINE_SIZE-1:0] imem_data_r;
  logic [CACHE_LINE_SIZE-1:0] dmem_data_r;

  logic                       imem_pend_s;
  logic                       dmem_pend_s;
  logic                       grant_s;
  port_id_t                   sel_port_s;
  logic                       sel_write_s;
  logic [IDX_W-1:0]           sel_index_s;
  logic [CACHE_LINE_SIZE-1:0] sel_wdata_s;
  logic                       mem_en_s;
  logic                       mem_we_s;
  logic [IDX_W-1:0]           mem_index_s;
  logic [CACHE_LINE_SIZE-1:0] mem_wdata_s;
  logic [CACHE_LINE_SIZE-1:0] mem_rdata_s;
  logic                       addr_unused_s;

  // Only the line-index bits of each address matter; offset and upper bits wrap away.
  assign addr_unused_s = ^{in_imem_addr, in_dmem_addr};

  // Request arbitration: a tie goes to the port not granted last.
  always_comb begin
    imem_pend_s = in_imem_read_en | in_imem_write_en;
    dmem_pend_s = in_dmem_read_en | in_dmem_write_en;
    grant_s     = imem_pend_s | dmem_pend_s;
    if (dmem_pend_s && (!imem_pend_s || (last_grant_r == PORT_IMEM))) begin
      sel_port_s = PORT_DMEM;
    end else begin
      sel_port_s = PORT_IMEM;
    end
    if (sel_port_s == PORT_DMEM) begin
      sel_write_s = in_dmem_write_en;
      sel_index_s = in_dmem_addr[OFF_W +: IDX_W];
      sel_wdata_s = in_dmem_write_data;
    end else begin
      sel_write_s = in_imem_write_en;
      sel_index_s = in_imem_addr[OFF_W +: IDX_W];
      sel_wdata_s = in_imem_write_data;
    end
  end

  // Store access happens in the cycle before RESP; with unit latency that is the grant cycle itself.
  always_comb begin
    if (state_r == IDLE) begin
      mem_en_s    = grant_s && (MEM_LATENCY == 1);
      mem_we_s    = sel_write_s;
      mem_index_s = sel_index_s;
      mem_wdata_s = sel_wdata_s;
    end else begin
      mem_en_s    = (state_r == BUSY) && (cnt_r == CNT_W'(1));
      mem_we_s    = req_write_r;
      mem_index_s = req_index_r;
      mem_wdata_s = req_wdata_r;
    end
  end

  main_memory_array #(
    .WIDTH    (CACHE_LINE_SIZE),
    .DEPTH    (MEM_DEPTH),
    .INIT_FILE(MEM_INIT_FILE)
  ) u_main_memory_array (
    .clk  (clk),
    .en   (mem_en_s),
    .we   (mem_we_s),
    .index(mem_index_s),
    .wdata(mem_wdata_s),
    .rdata(mem_rdata_s)
  );

  // Arbiter FSM, latency counter, request latches and per-port response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      last_grant_r <= PORT_IMEM;
      req_port_r   <= PORT_IMEM;
      req_write_r  <= 1'b0;
      req_index_r  <= {IDX_W{1'b0}};
      req_wdata_r  <= {CACHE_LINE_SIZE{1'b0}};
      imem_ready_r <= 1'b0;
      dmem_ready_r <= 1'b0;
      imem_data_r  <= {CACHE_LINE_SIZE{1'b0}};
      dmem_data_r  <= {CACHE_LINE_SIZE{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            req_port_r  <= sel_port_s;
            req_write_r <= sel_write_s;
            req_index_r <= sel_index_s;
            req_wdata_r <= sel_wdata_s;
            cnt_r       <= CNT_W'(MEM_LATENCY - 1);
            if (MEM_LATENCY == 1) begin
              state_r      <= RESP;
              imem_ready_r <= (sel_port_s == PORT_IMEM);
              dmem_ready_r <= (sel_port_s == PORT_DMEM);
            end else begin
              state_r <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt_r <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            state_r      <= RESP;
            imem_ready_r <= (req_port_r == PORT_IMEM);
            dmem_ready_r <= (req_port_r == PORT_DMEM);
          end
        end
        RESP: begin
          imem_ready_r <= 1'b0;
          dmem_ready_r <= 1'b0;
          if (!req_write_r) begin
            if (req_port_r == PORT_IMEM) begin
              imem_data_r <= mem_rdata_s;
            end else begin
              dmem_data_r <= mem_rdata_s;
            end
          end
          last_grant_r <= req_port_r;
          state_r      <= IDLE;
        end
        default: begin
          state_r      <= IDLE;
          imem_ready_r <= 1'b0;
          dmem_ready_r <= 1'b0;
        end
      endcase
    end
  end

  // During a read RESP the fresh line comes straight from the store's read register,
  // so data arrives together with ready; afterwards the captured copy holds it.
  // Both sources are registers, and ready is cleared by reset, so reset yields zeros.
  assign out_imem_read_data = (imem_ready_r && !req_write_r) ? mem_rdata_s : imem_data_r;
  assign out_dmem_read_data = (dmem_ready_r && !req_write_r) ? mem_rdata_s : dmem_data_r;
  assign out_imem_ready     = imem_ready_r;
  assign out_dmem_ready     = dmem_ready_r;

endmodule

// File: tb/tb_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_memory_arbiter
// Scoreboard bench for memory_arbiter: the stimulus process predicts each
// completion (port, cycle, data) from a line-indexed memory model and pushes
// it into a queue; a monitor pops and compares on every ready pulse.
// A second instance with MEM_LATENCY=1 covers the unit-latency case.
// ---------------------------------------------------------------------------
module tb_memory_arbiter;

  localparam int L = 5;

  typedef struct {
    int           port;
    int           cyc;
    logic [127:0] data;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         imem_re, imem_we, dmem_re, dmem_we;
  logic [31:0]  imem_addr, dmem_addr;
  logic [127:0] imem_wd, dmem_wd, imem_rd, dmem_rd;
  logic         imem_rdy, dmem_rdy;

  logic         l1_imem_re, l1_imem_we, l1_dmem_re, l1_dmem_we;
  logic [31:0]  l1_imem_addr, l1_dmem_addr;
  logic [127:0] l1_imem_wd, l1_dmem_wd, l1_imem_rd, l1_dmem_rd;
  logic         l1_imem_rdy, l1_dmem_rdy;

  int           cycle_cnt = 0;
  int           n_checks  = 0;
  int           n_fail    = 0;
  exp_t         sb_q[$];
  logic [127:0] mem_model [int];
  logic [127:0] prev_rd [2];
  int           last_grant_m;

  memory_arbiter #(.CACHE_LINE_SIZE(128), .MEM_DEPTH(4096), .MEM_LATENCY(L), .MEM_INIT_FILE("")) u_dut (
    .clk(clk), .reset(reset),
    .in_imem_read_en(imem_re), .in_imem_write_en(imem_we), .in_imem_addr(imem_addr),
    .in_imem_write_data(imem_wd), .out_imem_read_data(imem_rd), .out_imem_ready(imem_rdy),
    .in_dmem_read_en(dmem_re), .in_dmem_write_en(dmem_we), .in_dmem_addr(dmem_addr),
    .in_dmem_write_data(dmem_wd), .out_dmem_read_data(dmem_rd), .out_dmem_ready(dmem_rdy)
  );

  memory_arbiter #(.CACHE_LINE_SIZE(128), .MEM_DEPTH(4096), .MEM_LATENCY(1), .MEM_INIT_FILE("")) u_dut_l1 (
    .clk(clk), .reset(reset),
    .in_imem_read_en(l1_imem_re), .in_imem_write_en(l1_imem_we), .in_imem_addr(l1_imem_addr),
    .in_imem_write_data(l1_imem_wd), .out_imem_read_data(l1_imem_rd), .out_imem_ready(l1_imem_rdy),
    .in_dmem_read_en(l1_dmem_re), .in_dmem_write_en(l1_dmem_we), .in_dmem_addr(l1_dmem_addr),
    .in_dmem_write_data(l1_dmem_wd), .out_dmem_read_data(l1_dmem_rd), .out_dmem_ready(l1_dmem_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endtask

  // Monitor: every ready pulse must match the oldest predicted completion.
  task automatic check_port(input int p, input logic [127:0] d);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_ready: port %0d pulsed with nothing outstanding (cycle %0d)", p, cycle_cnt);
    end else begin
      e = sb_q.pop_front();
      chk("ready_port", 128'(p), 128'(e.port));
      chk("ready_cycle", 128'(cycle_cnt), 128'(e.cyc));
      chk("read_data", d, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (imem_rdy || dmem_rdy) chk("ready_exclusive", 128'(imem_rdy & dmem_rdy), 128'd0);
    if (imem_rdy) check_port(0, imem_rd);
    if (dmem_rdy) check_port(1, dmem_rd);
  end

  // Reference model: line = (addr / bytes_per_line) mod depth; a write leaves read_data alone.
  task automatic model_serve(input int p, input int cyc, input bit wr, input logic [31:0] addr,
                             input logic [127:0] wd);
    exp_t e;
    int   idx;
    idx = int'((addr / 32'd16) % 32'd4096);
    e.port = p;
    e.cyc  = cyc;
    if (wr) begin
      mem_model[idx] = wd;
      e.data = prev_rd[p];
    end else begin
      e.data = mem_model.exists(idx) ? mem_model[idx] : 128'hx;
      prev_rd[p] = e.data;
    end
    last_grant_m = p;
    sb_q.push_back(e);
  endtask

  // Issue one request on each enabled port in the same cycle, predict, then hold until served.
  task automatic do_batch(input bit i_on, input bit i_rd, input bit i_wr, input logic [31:0] i_addr,
                          input logic [127:0] i_wd, input bit d_on, input bit d_rd, input bit d_wr,
                          input logic [31:0] d_addr, input logic [127:0] d_wd);
    int c0;
    int first;
    int guard;
    bit i_left, d_left;
    c0 = cycle_cnt;
    imem_re = i_on & i_rd; imem_we = i_on & i_wr; imem_addr = i_addr; imem_wd = i_wd;
    dmem_re = d_on & d_rd; dmem_we = d_on & d_wr; dmem_addr = d_addr; dmem_wd = d_wd;
    if (i_on && d_on) first = (last_grant_m == 0) ? 1 : 0;
    else first = d_on ? 1 : 0;
    if (i_on || d_on) begin
      if (first == 0) model_serve(0, c0 + L, i_wr, i_addr, i_wd);
      else model_serve(1, c0 + L, d_wr, d_addr, d_wd);
    end
    if (i_on && d_on) begin
      if (first == 0) model_serve(1, c0 + 2 * L + 1, d_wr, d_addr, d_wd);
      else model_serve(0, c0 + 2 * L + 1, i_wr, i_addr, i_wd);
    end
    i_left = i_on;
    d_left = d_on;
    guard  = 0;
    while ((i_left || d_left) && guard < 3 * (L + 1) + 4) begin
      @(negedge clk);
      guard++;
      if (imem_rdy) begin i_left = 1'b0; imem_re = 1'b0; imem_we = 1'b0; end
      if (dmem_rdy) begin d_left = 1'b0; dmem_re = 1'b0; dmem_we = 1'b0; end
    end
    if (i_left || d_left) begin
      n_checks++;
      n_fail++;
      $display("FAIL batch_timeout: imem waiting %0d dmem waiting %0d after %0d cycles", i_left, d_left, guard);
      imem_re = 1'b0; imem_we = 1'b0; dmem_re = 1'b0; dmem_we = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Unit-latency instance: one request, ready expected in the very next cycle.
  task automatic l1_op(input bit use_d, input bit we, input logic [31:0] addr, input logic [127:0] wd,
                       input logic [127:0] exp);
    int c0;
    int guard;
    bit seen;
    c0 = cycle_cnt;
    if (use_d) begin l1_dmem_re = ~we; l1_dmem_we = we; l1_dmem_addr = addr; l1_dmem_wd = wd; end
    else begin l1_imem_re = ~we; l1_imem_we = we; l1_imem_addr = addr; l1_imem_wd = wd; end
    seen  = 1'b0;
    guard = 0;
    while (!seen && guard < 6) begin
      @(negedge clk);
      guard++;
      if (use_d ? l1_dmem_rdy : l1_imem_rdy) begin
        seen = 1'b1;
        chk("l1_ready_cycle", 128'(cycle_cnt), 128'(c0 + 1));
        chk("l1_read_data", use_d ? l1_dmem_rd : l1_imem_rd, exp);
        chk("l1_other_ready", 128'(use_d ? l1_imem_rdy : l1_dmem_rdy), 128'd0);
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL l1_timeout: no ready after %0d cycles", guard);
    end
    l1_imem_re = 1'b0; l1_imem_we = 1'b0; l1_dmem_re = 1'b0; l1_dmem_we = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] a5_line;
    logic [127:0] pat;
    logic [31:0]  r1, r2;
    int           c0;
    a5_line = {16{8'hA5}};
    reset = 1'b0;
    imem_re = 1'b0; imem_we = 1'b0; imem_addr = 32'd0; imem_wd = 128'd0;
    dmem_re = 1'b0; dmem_we = 1'b0; dmem_addr = 32'd0; dmem_wd = 128'd0;
    l1_imem_re = 1'b0; l1_imem_we = 1'b0; l1_imem_addr = 32'd0; l1_imem_wd = 128'd0;
    l1_dmem_re = 1'b0; l1_dmem_we = 1'b0; l1_dmem_addr = 32'd0; l1_dmem_wd = 128'd0;
    prev_rd[0] = 128'd0;
    prev_rd[1] = 128'd0;
    last_grant_m = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_imem_ready", 128'(imem_rdy), 128'd0);
    chk("reset_dmem_ready", 128'(dmem_rdy), 128'd0);
    chk("reset_imem_data", imem_rd, 128'd0);
    chk("reset_dmem_data", dmem_rd, 128'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Tie straight after reset: dcache first, icache one full transaction later.
    do_batch(1'b1, 1'b0, 1'b1, 32'h0000_0040, {4{32'hDEAD_0001}},
             1'b1, 1'b0, 1'b1, 32'h0000_0050, {4{32'hBEEF_0002}});
    // A lone dcache read makes dcache the last grant, so the next tie goes to icache.
    do_batch(1'b0, 1'b0, 1'b0, 32'd0, 128'd0, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 128'd0);
    do_batch(1'b1, 1'b1, 1'b0, 32'h0000_0040, 128'd0, 1'b1, 1'b1, 1'b0, 32'h0000_0054, 128'd0);

    // Seed lines 0..7 so every later read has a defined model value.
    for (int i = 0; i < 8; i++) begin
      pat = {$urandom(), $urandom(), $urandom(), $urandom()};
      do_batch(i[0], 1'b0, 1'b1, 32'(i * 16), pat, ~i[0], 1'b0, 1'b1, 32'(i * 16 + 4), pat);
    end

    // Offset bits ignored.
    do_batch(1'b0, 1'b0, 1'b0, 32'd0, 128'd0,
             1'b1, 1'b0, 1'b1, 32'h0000_2008, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321);
    do_batch(1'b0, 1'b0, 1'b0, 32'd0, 128'd0, 1'b1, 1'b1, 1'b0, 32'h0000_200C, 128'd0);

    // Line 0x10 holds the A5 pattern; icache read of 0x100.
    do_batch(1'b0, 1'b0, 1'b0, 32'd0, 128'd0, 1'b1, 1'b0, 1'b1, 32'h0000_0100, a5_line);
    do_batch(1'b1, 1'b1, 1'b0, 32'h0000_0100, 128'd0, 1'b0, 1'b0, 1'b0, 32'd0, 128'd0);

    // Wrap: 0x0001_0000 aliases line 0.
    do_batch(1'b0, 1'b0, 1'b0, 32'd0, 128'd0, 1'b1, 1'b0, 1'b1, 32'h0001_0000, {4{32'h0F0F_1357}});
    do_batch(1'b1, 1'b1, 1'b0, 32'h0000_0000, 128'd0, 1'b0, 1'b0, 1'b0, 32'd0, 128'd0);

    // read_en and write_en together is a write; read_data holds.
    do_batch(1'b1, 1'b1, 1'b1, 32'h0000_0060, {4{32'h6060_ABCD}}, 1'b0, 1'b0, 1'b0, 32'd0, 128'd0);
    do_batch(1'b1, 1'b1, 1'b0, 32'h0000_0064, 128'd0, 1'b0, 1'b0, 1'b0, 32'd0, 128'd0);

    // Reset in cycle 2 of a write: abandoned, store untouched, outputs zero under reset.
    c0 = cycle_cnt;
    dmem_we = 1'b1; dmem_addr = 32'h0000_0100; dmem_wd = {4{32'h7777_8888}};
    while (cycle_cnt < c0 + 2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_mid_imem_ready", 128'(imem_rdy), 128'd0);
    chk("rst_mid_dmem_ready", 128'(dmem_rdy), 128'd0);
    chk("rst_mid_imem_data", imem_rd, 128'd0);
    chk("rst_mid_dmem_data", dmem_rd, 128'd0);
    repeat (4) @(negedge clk);
    chk("rst_hold_dmem_ready", 128'(dmem_rdy), 128'd0);
    dmem_we = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    last_grant_m = 0;
    prev_rd[0] = 128'd0;
    prev_rd[1] = 128'd0;
    repeat (L + 2) @(posedge clk);
    #1;
    do_batch(1'b1, 1'b1, 1'b0, 32'h0000_0100, 128'd0, 1'b0, 1'b0, 1'b0, 32'd0, 128'd0);

    // Randomized traffic over lines 0..7 with random offsets and wrap bits.
    for (int n = 0; n < 60; n++) begin
      int  mode, iop, dop, iline, dline, gap;
      mode  = $urandom_range(0, 2);
      iop   = $urandom_range(0, 3);
      dop   = $urandom_range(0, 3);
      iline = $urandom_range(0, 7);
      dline = $urandom_range(0, 7);
      r1 = $urandom();
      r2 = $urandom();
      do_batch(mode != 1, iop != 2, iop >= 2, (r1 & 32'hFFFF_0000) | 32'(iline * 16) | (r2 & 32'hF),
               {$urandom(), $urandom(), $urandom(), $urandom()},
               mode != 0, dop != 2, dop >= 2, (r2 & 32'hFFFF_0000) | 32'(dline * 16) | (r1 & 32'hF),
               {$urandom(), $urandom(), $urandom(), $urandom()});
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end

    repeat (2 * (L + 1)) @(posedge clk);
    #1;
    chk("scoreboard_drained", 128'(sb_q.size()), 128'd0);

    // Unit latency: ready arrives one cycle after the request.
    l1_op(1'b1, 1'b1, 32'h0000_0030, {4{32'hC0DE_0001}}, 128'd0);
    l1_op(1'b0, 1'b0, 32'h0000_0030, 128'd0, {4{32'hC0DE_0001}});
    l1_op(1'b1, 1'b0, 32'h0001_0034, 128'd0, {4{32'hC0DE_0001}});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
